// File: rtl/y86_pkg.sv
// Shared definitions for the sequential Y86-64 core:
// icodes, status codes and the stage-state encoding.
package y86_pkg;

   localparam logic [3:0] HALT   = 4'd0;
   localparam logic [3:0] NOP    = 4'd1;
   localparam logic [3:0] CMOVXX = 4'd2;
   localparam logic [3:0] IRMOVQ = 4'd3;
   localparam logic [3:0] RMMOVQ = 4'd4;
   localparam logic [3:0] MRMOVQ = 4'd5;
   localparam logic [3:0] OPQ    = 4'd6;
   localparam logic [3:0] JXX    = 4'd7;
   localparam logic [3:0] CALL   = 4'd8;
   localparam logic [3:0] RET    = 4'd9;
   localparam logic [3:0] PUSHQ  = 4'd10;
   localparam logic [3:0] POPQ   = 4'd11;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_PCUPDATE,
      S_HALTED
   } stage_e;

   function automatic logic is_mem_icode(input logic [3:0] ic);
      return ic inside {RMMOVQ, MRMOVQ, CALL, RET, PUSHQ, POPQ};
   endfunction

endpackage

// File: rtl/seq_stage_controller_if.sv
// Control bundle between the sequencer and the
// fetch/memory side of the datapath.
interface seq_stage_controller_if;

   logic        start;
   logic [3:0]  icode;
   logic        instr_valid;
   logic        imem_error;
   logic        mem_ready;
   logic        dmem_error;
   logic        fetch_en;
   logic        decode_en;
   logic        execute_en;
   logic        memory_en;
   logic        writeback_en;
   logic        pc_update_en;
   logic [2:0]  stat;
   logic        running;
   logic [31:0] instr_count;

   modport master (
      input  start, icode, instr_valid, imem_error,
      input  mem_ready, dmem_error,
      output fetch_en, decode_en, execute_en,
      output memory_en, writeback_en, pc_update_en,
      output stat, running, instr_count
   );

   modport slave (
      output start, icode, instr_valid, imem_error,
      output mem_ready, dmem_error,
      input  fetch_en, decode_en, execute_en,
      input  memory_en, writeback_en, pc_update_en,
      input  stat, running, instr_count
   );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts MEMORY stall cycles; timeout_o flags that one
// more stall reaches STALL_MAX.
module mem_wait_timer #(
   parameter int unsigned STALL_MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic stall_i,
   output logic timeout_o
);

   localparam logic [7:0] LIM = 8'(STALL_MAX - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = 8'd0;
      else if (stall_i)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= 8'd0;
      else
         cnt_q <= cnt_d;
   end

   assign timeout_o = (cnt_q == LIM);

endmodule

// File: rtl/seq_stage_controller.sv
// One-instruction-at-a-time stage sequencer with
// halt/status tracking and retired-instruction count.
module seq_stage_controller
   import y86_pkg::*;
#(
   parameter int unsigned STALL_MAX = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   seq_stage_controller_if.master bus
);

   stage_e      state_q, state_d;
   logic [2:0]  stat_q, stat_d;
   logic [31:0] cnt_q, cnt_d;
   logic        tmr_clr;
   logic        tmr_stall;
   logic        tmr_timeout;

   mem_wait_timer #(.STALL_MAX(STALL_MAX)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (tmr_clr),
      .stall_i   (tmr_stall),
      .timeout_o (tmr_timeout)
   );

   always_comb begin
      state_d   = state_q;
      stat_d    = stat_q;
      cnt_d     = cnt_q;
      tmr_clr   = 1'b0;
      tmr_stall = 1'b0;
      unique case (state_q)
         S_IDLE:      if (bus.start) state_d = S_FETCH;
         S_FETCH:     state_d = S_DECODE;
         S_DECODE: begin
            if (bus.imem_error) begin
               state_d = S_HALTED;
               stat_d  = STAT_ADR;
            end else if (!bus.instr_valid) begin
               state_d = S_HALTED;
               stat_d  = STAT_INS;
            end else if (bus.icode == HALT) begin
               state_d = S_HALTED;
               stat_d  = STAT_HLT;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            state_d = S_MEMORY;
            tmr_clr = 1'b1;
         end
         S_MEMORY: begin
            if (!is_mem_icode(bus.icode)) begin
               state_d = S_WRITEBACK;
            end else if (bus.dmem_error) begin
               state_d = S_HALTED;
               stat_d  = STAT_ADR;
            end else if (bus.mem_ready) begin
               state_d = S_WRITEBACK;
            end else begin
               tmr_stall = 1'b1;
               if (tmr_timeout) begin
                  state_d = S_HALTED;
                  stat_d  = STAT_ADR;
               end
            end
         end
         S_WRITEBACK: state_d = S_PCUPDATE;
         S_PCUPDATE: begin
            state_d = S_FETCH;
            cnt_d   = cnt_q + 32'd1;
         end
         S_HALTED:    state_d = S_HALTED;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         stat_q  <= STAT_AOK;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         stat_q  <= stat_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.fetch_en     = (state_q == S_FETCH);
   assign bus.decode_en    = (state_q == S_DECODE);
   assign bus.execute_en   = (state_q == S_EXECUTE);
   assign bus.memory_en    = (state_q == S_MEMORY);
   assign bus.writeback_en = (state_q == S_WRITEBACK);
   assign bus.pc_update_en = (state_q == S_PCUPDATE);
   assign bus.running      = (state_q != S_IDLE) &&
                             (state_q != S_HALTED);
   assign bus.stat         = stat_q;
   assign bus.instr_count  = cnt_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed bench for seq_stage_controller with a timeline
// model checked every cycle plus literal spot checks.
module tb_seq_stage_controller;

   localparam int SM = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   chk_on = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   seq_stage_controller_if bus();

   seq_stage_controller #(.STALL_MAX(SM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] en_vec();
      return {26'd0, bus.fetch_en, bus.decode_en, bus.execute_en,
              bus.memory_en, bus.writeback_en, bus.pc_update_en};
   endfunction

   // Model: mode 0 idle, 1 running, 2 halted. Within an instruction,
   // pos counts cycles since FETCH and w counts memory stalls, so the
   // active stage index is pos for the first three cycles, then pos-w.
   int          m_mode = 0;
   int          m_pos  = 0;
   int          m_w    = 0;
   logic [2:0]  m_stat = 3'd1;
   logic [31:0] m_cnt  = 32'd0;

   always @(negedge clk) begin
      int stg;
      logic [5:0] een;
      bit memi;
      if (chk_on) begin
         stg = (m_pos < 3) ? m_pos : m_pos - m_w;
         een = (m_mode == 1) ? (6'b100000 >> stg) : 6'b000000;
         chk("model_en", en_vec(), {26'd0, een});
         chk("model_stat", {29'd0, bus.stat}, {29'd0, m_stat});
         chk("model_running", {31'd0, bus.running},
             {31'd0, m_mode == 1});
         chk("model_count", bus.instr_count, m_cnt);
         memi = bus.icode inside {4, 5, 8, 9, 10, 11};
         if (rst) begin
            m_mode = 0; m_pos = 0; m_w = 0;
            m_stat = 3'd1; m_cnt = 32'd0;
         end else if (m_mode == 0) begin
            if (bus.start) begin
               m_mode = 1; m_pos = 0; m_w = 0;
            end
         end else if (m_mode == 1) begin
            if (stg == 1) begin
               if (bus.imem_error) begin
                  m_mode = 2; m_stat = 3'd3;
               end else if (!bus.instr_valid) begin
                  m_mode = 2; m_stat = 3'd4;
               end else if (bus.icode == 4'd0) begin
                  m_mode = 2; m_stat = 3'd2;
               end else m_pos++;
            end else if (stg == 3 && memi) begin
               if (bus.dmem_error) begin
                  m_mode = 2; m_stat = 3'd3;
               end else if (bus.mem_ready) begin
                  m_pos++;
               end else begin
                  m_w++; m_pos++;
                  if (m_w == SM) begin
                     m_mode = 2; m_stat = 3'd3;
                  end
               end
            end else if (stg == 5) begin
               m_cnt++; m_pos = 0; m_w = 0;
            end else m_pos++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   logic [5:0] tbl [7];
   int n;
   int mc;

   initial begin
      tbl = '{6'b100000, 6'b010000, 6'b001000, 6'b000100,
              6'b000010, 6'b000001, 6'b100000};
      bus.start = 1'b0;
      bus.icode = 4'd1;
      bus.instr_valid = 1'b1;
      bus.imem_error = 1'b0;
      bus.mem_ready = 1'b0;
      bus.dmem_error = 1'b0;
      @(posedge clk);
      chk_on = 1'b1;
      #1;
      chk("reset_count", bus.instr_count, 32'd0);
      chk("reset_stat", {29'd0, bus.stat}, 32'd1);
      chk("reset_en", en_vec(), 32'd0);
      rst = 1'b0;

      // NOP timeline
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         chk("nop_en", en_vec(), {26'd0, tbl[i]});
         if (i < 6) tick();
      end
      chk("nop_count", bus.instr_count, 32'd1);

      // MRMOVQ with three stall cycles
      bus.icode = 4'd5;
      n = 0; mc = 0;
      do begin
         tick();
         n++;
         if (bus.memory_en) mc++;
         bus.mem_ready = (mc >= 4);
      end while (!bus.fetch_en && n < 40);
      bus.mem_ready = 1'b0;
      chk("mrmov_cycles", n, 9);
      chk("mrmov_mem_en", mc, 4);
      chk("mrmov_stat", {29'd0, bus.stat}, 32'd1);
      chk("mrmov_count", bus.instr_count, 32'd2);

      // HALT instruction, then start ignored
      bus.icode = 4'd0;
      tick();
      tick();
      chk("hlt_stat", {29'd0, bus.stat}, 32'd2);
      chk("hlt_running", {31'd0, bus.running}, 32'd0);
      chk("hlt_count", bus.instr_count, 32'd2);
      bus.start = 1'b1;
      tick();
      tick();
      bus.start = 1'b0;
      chk("hlt_absorb", {31'd0, bus.running}, 32'd0);

      // ADR beats INS in decode
      do_reset();
      bus.icode = 4'd1;
      bus.instr_valid = 1'b0;
      bus.imem_error = 1'b1;
      pulse_start();
      tick();
      tick();
      chk("dec_adr_stat", {29'd0, bus.stat}, 32'd3);
      do_reset();
      bus.imem_error = 1'b0;
      pulse_start();
      tick();
      tick();
      chk("dec_ins_stat", {29'd0, bus.stat}, 32'd4);
      chk("dec_ins_count", bus.instr_count, 32'd0);
      bus.instr_valid = 1'b1;

      // PUSHQ memory timeout
      do_reset();
      bus.icode = 4'd10;
      pulse_start();
      n = 0; mc = 0;
      while (bus.running && n < 100) begin
         if (bus.memory_en) mc++;
         tick();
         n++;
      end
      chk("tmo_mem_cycles", mc, 15);
      chk("tmo_ticks", n, 18);
      chk("tmo_stat", {29'd0, bus.stat}, 32'd3);

      // dmem_error wins over mem_ready
      do_reset();
      bus.icode = 4'd4;
      pulse_start();
      tick();
      tick();
      tick();
      chk("derr_in_mem", {31'd0, bus.memory_en}, 32'd1);
      bus.dmem_error = 1'b1;
      bus.mem_ready = 1'b1;
      tick();
      bus.dmem_error = 1'b0;
      bus.mem_ready = 1'b0;
      chk("derr_stat", {29'd0, bus.stat}, 32'd3);
      chk("derr_running", {31'd0, bus.running}, 32'd0);

      // reset during a memory wait
      do_reset();
      bus.icode = 4'd1;
      pulse_start();
      for (int i = 0; i < 6; i++) tick();
      chk("rstw_pre_count", bus.instr_count, 32'd1);
      bus.icode = 4'd11;
      for (int i = 0; i < 5; i++) tick();
      chk("rstw_waiting", {31'd0, bus.memory_en}, 32'd1);
      rst = 1'b1;
      tick();
      chk("rstw_en", en_vec(), 32'd0);
      chk("rstw_count", bus.instr_count, 32'd0);
      chk("rstw_stat", {29'd0, bus.stat}, 32'd1);
      bus.start = 1'b1;
      tick();
      chk("rst_start_idle", {31'd0, bus.running}, 32'd0);
      rst = 1'b0;
      bus.start = 1'b0;
      tick();
      chk("idle_hold", {31'd0, bus.running}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/seq_stage_controller.md
# seq_stage_controller

Sequencing controller for the sequential Y86-64 core. An FSM issues one-hot stage enables (fetch, decode, execute, memory, writeback, PC update) for one instruction at a time. It waits on the data-memory handshake for memory-touching instructions and halts with a Y86 status code on `halt`, an invalid instruction, an address error or a memory timeout. It sits above the fetch, decode, execute, memory and writeback blocks and is the only source of their enables.

## Interface
- `STALL_MAX`, 15: cycles allowed with `mem_ready` low in MEMORY before an ADR halt; range 1..255.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin execution; honoured only in IDLE.
- `icode`  in  4  instruction code from fetch; valid from the DECODE cycle onward.
- `instr_valid`  in  1  fetch reports a legal icode/ifun; sampled in DECODE.
- `imem_error`  in  1  fetch address error; sampled in DECODE.
- `mem_ready`  in  1  data memory completed the access this cycle.
- `dmem_error`  in  1  data memory address error; sampled in MEMORY.
- `fetch_en`, `decode_en`, `execute_en`, `memory_en`, `writeback_en`, `pc_update_en`  out  1 each  stage enables; at most one high per cycle.
- `stat`  out  3  Y86 status: AOK=1, HLT=2, ADR=3, INS=4.
- `running`  out  1  high in every state except IDLE and HALTED.
- `instr_count`  out  32  retired instructions; wraps modulo 2^32.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALTED.
- IDLE -> FETCH on `start`. Otherwise the FSM stays in IDLE.
- FETCH -> DECODE unconditionally.
- DECODE checks run in priority order: `imem_error` -> HALTED with stat=ADR; `!instr_valid` -> HALTED with INS; `icode==0` -> HALTED with HLT; else -> EXECUTE.
- EXECUTE -> MEMORY unconditionally.
- MEMORY, memory instruction (icode 4, 5, 8, 9, 10, 11):
  - `dmem_error` -> HALTED with ADR. Error wins over a simultaneous `mem_ready`.
  - Else `mem_ready` -> WRITEBACK.
  - Else increment the wait counter. When the counter reaches `STALL_MAX`, go to HALTED with ADR.
- MEMORY, all other icodes: one cycle, then -> WRITEBACK. `mem_ready` and `dmem_error` are ignored.
- WRITEBACK -> PCUPDATE.
- PCUPDATE -> FETCH. `instr_count` increments on this transition.
- HALTED is absorbing. Only `rst` leaves it; `start` is ignored.
- Wait counter: 8 bits, cleared on entry to MEMORY.
- `start` outside IDLE is ignored. `stat` is held at AOK until a halt, then frozen.

## Timing
- Enables are Moore outputs decoded from the state register. Each is high for exactly the cycles its state is current.
- `memory_en` stays high through all wait cycles.
- Non-memory instruction: 6 cycles, FETCH through PCUPDATE. Memory instruction: 6 + (cycles `mem_ready` is low).
- First `fetch_en` appears one cycle after `start` is sampled high.
- Halt on a DECODE error: HALTED is entered the cycle after DECODE. EXECUTE and later enables never assert for the faulting instruction, and `instr_count` does not increment.
- Reset values: state IDLE, all enables 0, `stat`=1 (AOK), `running`=0, `instr_count`=0, wait counter 0.
- `rst` mid-instruction takes the FSM to IDLE on the next edge, aborting the current stage. No partial increment.
- `rst` and `start` high together: reset wins; FSM stays in IDLE.

## Structure
- Shared package `y86_pkg`:
  - icode constants HALT=0, NOP=1, CMOVXX=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=10, POPQ=11.
  - Stat constants STAT_AOK/HLT/ADR/INS.
  - Stage-state enum.
  - Function `is_mem_icode(icode)`.
- One sub-module `mem_wait_timer`: clear and count on stall, with a `timeout` output compared against `STALL_MAX`. Everything else stays in the top FSM.

## Test plan
- Reset, then `start`, then icode=1 (NOP) with `mem_ready` held 0 → enables fetch..pc_update on cycles 1..6, then fetch again on cycle 7; `instr_count`=1 after PCUPDATE.
- icode=5 (MRMOVQ) with `mem_ready` low 3 cycles, then high → `memory_en` high 4 cycles; instruction takes 9 cycles; stat=1.
- icode=0 → HALTED the cycle after DECODE, stat=2, `running`=0, `instr_count` unchanged; a later `start` has no effect.
- `instr_valid`=0 together with `imem_error`=1 → stat=3 (ADR wins); `instr_valid`=0 alone → stat=4.
- icode=10 (PUSHQ) with `mem_ready` never high and `STALL_MAX`=15 → ADR halt after 15 MEMORY cycles; `dmem_error` and `mem_ready` high together → ADR.
- `rst` asserted during MEMORY wait → next cycle IDLE, all outputs at reset values, `instr_count`=0.
